serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial add controller that time-multiplexes a single existing FullAdder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It accepts operand pairs over a valid/ready handshake, sequences the carry through a carry flop, assembles the sum in a shift register, and presents the result over a second valid/ready handshake. It is the area-minimal counterpart to the ripple-carry adder and sits between an operand producer and a result consumer.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1 to 64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair and cin are valid
- in_ready  output  1  controller can accept an operand pair
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for the operation
- op_sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry-out of the MSB
- busy  output  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, cin (and op_sub) into internal registers. Set the bit counter to 0. Load the carry flop with cin. Go to RUN.
- RUN: the FullAdder inputs are a_sh[0], b_sh[0] and the carry flop. Each cycle:
  - shift the FullAdder sum bit into sum_sh at the MSB;
  - shift a_sh and b_sh right by one;
  - load the carry flop with the FullAdder carry-out;
  - increment the counter.
- RUN exit: when counter==WIDTH-1 at a clock edge, that edge performs the last bit and the FSM goes to DONE.
- DONE: out_valid=1. sum=sum_sh and cout=carry flop, both held stable. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored (in_ready=0); the operands are not queued.
- Operand inputs may change freely after capture without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- Reset (asserted at any time, including mid-RUN or in DONE): the FSM goes to IDLE and the operation in flight is discarded without a result.
  - Reset values: in_ready=1 (once rst_n is high), out_valid=0, busy=0, sum=0, cout=0, all internal shift registers, counter and carry flop 0.

## Timing
- in_ready, out_valid and busy decode from registered state only; there is no combinational in->out path.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Minimum initiation interval: WIDTH+2 cycles, made up of WIDTH RUN cycles, at least one DONE cycle and one IDLE cycle.
- out_ready held high ahead of time: DONE lasts exactly one cycle.
- WIDTH=1: RUN lasts one cycle and the counter compare is still correct.
- Counter width: $clog2(WIDTH)+1 bits.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - the op_sub port exists and is captured with the operands;
  - when op_sub=1, b is inverted on capture, the carry flop is loaded with 1, and cin is ignored;
  - result: sum = a - b mod 2^WIDTH, and cout=1 means no borrow.
- Macro undefined: the op_sub port and its logic are absent, and the block is add-only.

## Structure
- Package serial_add_pkg holds:
  - the state typedef (enum IDLE/RUN/DONE, 2 bits);
  - the constant SERIAL_ADD_DEFAULT_WIDTH=8.
- One sub-module: a single instance of the existing FullAdder cell for the bit datapath.
- FSM, counter, shift registers and carry flop live in serial_adder_ctrl.

## Test plan
- Reset: hold rst_n low 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Basic add, WIDTH=8: a=8'h3C, b=8'h5A, cin=0 -> sum=8'h96, cout=0; out_valid rises exactly 8 edges after accept.
- Carry chain: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1. Also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: result pending with out_ready low for 5 cycles and in_valid high with new operands -> sum and cout held, in_ready=0, new operands not captured. Raise out_ready -> IDLE, then the new pair is accepted.
- Reset mid-RUN: pulse rst_n low after 3 RUN cycles -> no out_valid. Then a=8'h10, b=8'h20, cin=0 -> sum=8'h30, cout=0.
- With SERIAL_ADD_SUB_EN:
  - a=8'h05, b=8'h07, op_sub=1, cin=1 -> sum=8'hFE, cout=0;
  - a=8'h07, b=8'h05, op_sub=1 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_pkg
// Purpose : Shared types and constants for the bit-serial add controller.
//           - serial_add_state_e : controller FSM encoding (IDLE/RUN/DONE)
//           - SERIAL_ADD_DEFAULT_WIDTH : default operand width
// Rev     : 1.0  initial release
// ============================================================================
package serial_add_pkg;

  localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_e;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa.sv
`default_nettype none
// ============================================================================
// Module  : FullAdder
// Purpose : Single-bit full adder cell used as the serial datapath.
// Ports   : a_i, b_i, ci_i  - addend bits and carry-in
//           s_o              - sum bit
//           co_o             - carry-out
// Rev     : 1.0  initial release
// ============================================================================
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule : FullAdder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Purpose : Bit-serial adder controller. Adds two WIDTH-bit operands one bit
//           per clock (LSB first) through a single FullAdder cell.
// Ports   : clk, rst_n             - clock, async active-low reset
//           in_valid/in_ready      - operand handshake (a, b, cin[, op_sub])
//           out_valid/out_ready    - result handshake (sum, cout)
//           busy                   - high while RUN or DONE
// Config  : SERIAL_ADD_SUB_EN - adds op_sub port; op_sub=1 computes a-b
//           (cout=1 means no borrow) and ignores cin.
// Rev     : 1.0  initial release
// ============================================================================
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  serial_add_state_e state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;

  logic fa_s, fa_co;

  FullAdder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
`ifdef SERIAL_ADD_SUB_EN
          // Two's complement subtract: a + ~b + 1.
          if (op_sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end
`endif
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 holds
        // the first (LSB) result bit.
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_s;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        carry_d             = fa_co;
        cnt_d               = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule : serial_adder_ctrl
`default_nettype wire
